// File: rtl/commutator.sv
// Registered rotating crossbar: lane k takes inputs[(control + k) mod N_IN] when its enable is set.
// Reset is synchronous and active-low. Outputs are driven directly from flops.
module commutator #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 3,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] control,
  input  logic [N_OUT-1:0] lane_en,
  input  logic [N_IN-1:0]  inputs,
  output logic [N_OUT-1:0] outputs
);

  logic [N_OUT-1:0][SEL_W-1:0] idx_s;
  logic [N_OUT-1:0]            outputs_d;
  logic [N_OUT-1:0]            outputs_q;

  // Per-lane source index; the SEL_W-bit sum drops the carry, so the rotation wraps modulo N_IN.
  always_comb begin
    idx_s = '0;
    for (int k = 0; k < N_OUT; k++) begin
      idx_s[k] = control + SEL_W'(k);
    end
  end

  // Next lane values: a lane loads its selected source when enabled and holds otherwise.
  always_comb begin
    outputs_d = outputs_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (lane_en[k]) begin
        outputs_d[k] = inputs[idx_s[k]];
      end else begin
        outputs_d[k] = outputs_q[k];
      end
    end
  end

  // Lane registers; reset clears every lane and takes priority over the enables.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outputs_q <= '0;
    end else begin
      outputs_q <= outputs_d;
    end
  end

  assign outputs = outputs_q;

endmodule

// File: tb/tb_commutator.sv
// Self-checking bench for commutator: directed vector table, hold sequences,
// and randomized traffic compared with a behavioural model.
module tb_commutator;

  logic       clk;
  logic       rst_n;
  logic [2:0] control;
  logic [2:0] lane_en;
  logic [7:0] inputs;
  logic [2:0] outputs;

  int checks;
  int failures;

  commutator #(.N_IN(8), .N_OUT(3), .SEL_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .control (control),
    .lane_en (lane_en),
    .inputs  (inputs),
    .outputs (outputs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [2:0] control;
    logic [2:0] lane_en;
    logic [7:0] inputs;
    logic [2:0] expected;
    string      name;
  } vec_t;

  vec_t vecs[15];

  // Drive one set of inputs, let one rising edge pass, then compare away from the edge.
  task automatic apply(input logic r, input logic [2:0] c, input logic [2:0] e,
                       input logic [7:0] i, input logic [2:0] exp_o, input string name);
    rst_n   = r;
    control = c;
    lane_en = e;
    inputs  = i;
    @(posedge clk);
    #1;
    checks++;
    if (outputs !== exp_o) begin
      failures++;
      $display("FAIL %s: outputs=%b expected=%b (control=%0d lane_en=%b inputs=%b)",
               name, outputs, exp_o, c, e, i);
    end
  endtask

  logic [2:0] model;
  logic       r_v;
  logic [2:0] c_v;
  logic [2:0] e_v;
  logic [7:0] i_v;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    control  = 3'd0;
    lane_en  = 3'b000;
    inputs   = 8'h00;

    vecs[0]  = '{1'b0, 3'd5, 3'b111, 8'hFF,        3'b000, "reset"};
    vecs[1]  = '{1'b0, 3'd2, 3'b111, 8'hFF,        3'b000, "reset_hold"};
    vecs[2]  = '{1'b1, 3'd0, 3'b111, 8'b0000_0101, 3'b101, "basic"};
    vecs[3]  = '{1'b1, 3'd6, 3'b111, 8'b1000_0001, 3'b110, "wrap6"};
    vecs[4]  = '{1'b1, 3'd0, 3'b111, 8'b1010_0110, 3'b110, "sweep0"};
    vecs[5]  = '{1'b1, 3'd1, 3'b111, 8'b1010_0110, 3'b011, "sweep1"};
    vecs[6]  = '{1'b1, 3'd2, 3'b111, 8'b1010_0110, 3'b001, "sweep2"};
    vecs[7]  = '{1'b1, 3'd3, 3'b111, 8'b1010_0110, 3'b100, "sweep3"};
    vecs[8]  = '{1'b1, 3'd4, 3'b111, 8'b1010_0110, 3'b010, "sweep4"};
    vecs[9]  = '{1'b1, 3'd5, 3'b111, 8'b1010_0110, 3'b101, "sweep5"};
    vecs[10] = '{1'b1, 3'd6, 3'b111, 8'b1010_0110, 3'b010, "sweep6"};
    vecs[11] = '{1'b1, 3'd7, 3'b111, 8'b1010_0110, 3'b101, "sweep7"};
    vecs[12] = '{1'b1, 3'd0, 3'b111, 8'b0000_0111, 3'b111, "preload"};
    vecs[13] = '{1'b1, 3'd0, 3'b010, 8'h00,        3'b101, "lane1_only"};
    vecs[14] = '{1'b1, 3'd3, 3'b100, 8'h00,        3'b001, "lane2_only"};

    for (int v = 0; v < 14; v++) begin
      apply(vecs[v].rst_n, vecs[v].control, vecs[v].lane_en, vecs[v].inputs,
            vecs[v].expected, vecs[v].name);
    end

    // All lanes disabled: random control/inputs must not disturb the held 3'b101.
    for (int n = 0; n < 5; n++) begin
      apply(1'b1, 3'($urandom_range(7)), 3'b000, 8'($urandom), 3'b101, "freeze");
    end

    apply(vecs[14].rst_n, vecs[14].control, vecs[14].lane_en, vecs[14].inputs,
          vecs[14].expected, vecs[14].name);

    // Randomized traffic against the behavioural model, with reset pulses mid-stream.
    model = 3'b001;
    for (int n = 0; n < 300; n++) begin
      r_v = !((n == 150) || ($urandom_range(39) == 0));
      c_v = 3'($urandom_range(7));
      e_v = 3'($urandom_range(7));
      i_v = 8'($urandom);
      for (int k = 0; k < 3; k++) begin
        if (!r_v) model[k] = 1'b0;
        else if (e_v[k]) model[k] = i_v[(int'(c_v) + k) % 8];
      end
      apply(r_v, c_v, e_v, i_v, model, r_v ? "random" : "random_reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
